// File: rtl/async_fifo_rd_ctrl_pkg.sv
// Shared definitions for both sides of the dual-clock FIFO:
// pointer width and Gray/binary conversion helpers.
package async_fifo_rd_ctrl_pkg;

    localparam int unsigned ADDRSIZE_DEF = 4;
    localparam int unsigned PTRSIZE_DEF  = ADDRSIZE_DEF + 1;

    function automatic logic [31:0] bin2gray(
        input logic [31:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(
        input logic [31:0] g
    );
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Ports: gray_i (W) Gray code in, bin_o (W) binary out.
module async_fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < W; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (rclk domain only).
// Ports: rclk/rrst_n clock and async low reset; rq2_wptr synced Gray
//   write pointer; rdata_mem RAM data at raddr; rptr Gray read pointer
//   to write side; rempty RAM empty; rvalid/rready/rdata registered
//   FWFT output; rlevel words held; ralmost_empty rlevel <= AE_LEVEL.
module async_fifo_rd_ctrl
    import async_fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int DSIZE    = 8,
    parameter int AE_LEVEL = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DSIZE-1:0]    rdata_mem,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rempty,
    output logic                rvalid,
    input  logic                rready,
    output logic [DSIZE-1:0]    rdata,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                ralmost_empty
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic [PW-1:0]    rbin_q, rbin_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    rlevel_q, rlevel_d;
    logic [PW-1:0]    wbin;
    logic             rempty_q, rempty_d;
    logic             rvalid_q, rvalid_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             load;

    async_fifo_gray2bin #(
        .W (PW)
    ) u_wbin (
        .gray_i (rq2_wptr),
        .bin_o  (wbin)
    );

    always_comb begin
        load     = !rempty_q && (!rvalid_q || rready);
        rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, load};
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        // Full Gray compare: the extra MSB separates
        // empty from a full wrap of the RAM.
        rempty_d = (rptr_d == rq2_wptr);
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        if (load) begin
            rdata_d  = rdata_mem;
            rvalid_d = 1'b1;
        end else if (rready) begin
            rvalid_d = 1'b0;
        end
        // Unread RAM words after this edge, plus the
        // word that will sit in the output register.
        rlevel_d = (wbin - rbin_d)
                 + {{ADDRSIZE{1'b0}}, rvalid_d};
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlevel_q <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rlevel_q <= rlevel_d;
        end
    end

    assign rptr          = rptr_q;
    assign raddr         = rbin_q[ADDRSIZE-1:0];
    assign rempty        = rempty_q;
    assign rvalid        = rvalid_q;
    assign rdata         = rdata_q;
    assign rlevel        = rlevel_q;
    assign ralmost_empty = (rlevel_q <= AE_THR);

endmodule

// File: doc/async_fifo_rd_ctrl.md
# async_fifo_rd_ctrl

Read-side controller of the dual-clock FIFO, running entirely in the read clock domain. It consumes the write pointer already synchronized into the read domain and owns the Gray read pointer handed back to the write domain. It also owns the read address to the dual-port RAM, and drives a registered first-word-fall-through valid/ready output stage with empty, level and almost-empty status.

## Interface
Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- DSIZE, 8, data width.
- AE_LEVEL, 2, almost-empty threshold in words.

Ports:
- rclk  in  1  read clock; one clock only; all state on rising edge.
- rrst_n  in  1  asynchronous, active-low reset.
- rq2_wptr  in  ADDRSIZE+1  Gray write pointer, already double-synchronized into rclk.
- rdata_mem  in  DSIZE  RAM read data; combinational on raddr.
- rptr  out  ADDRSIZE+1  Gray read pointer, registered, to write-domain synchronizer.
- raddr  out  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0].
- rempty  out  1  RAM holds no unread word (output register excluded).
- rvalid  out  1  rdata holds a valid word.
- rready  in  1  consumer accepts rdata this cycle.
- rdata  out  DSIZE  registered output word.
- rlevel  out  ADDRSIZE+1  words held: unread RAM words plus rvalid.
- ralmost_empty  out  1  rlevel <= AE_LEVEL.

## Operation
- State: rbin (binary read pointer), rptr, rempty, rvalid, rdata, rlevel.
- Reset values: rbin=0, rptr=0, rempty=1, rvalid=0, rdata=0, rlevel=0; ralmost_empty therefore 1.
- load = !rempty && (!rvalid || rready).
- rbinnext = rbin + load (mod 2^(ADDRSIZE+1)); rgraynext = (rbinnext>>1) ^ rbinnext.
- Each cycle: rbin<=rbinnext; rptr<=rgraynext; rempty<=(rgraynext == rq2_wptr).
- Output stage: if load, rdata<=rdata_mem and rvalid<=1. Else if rready, rvalid<=0. Otherwise hold.
- rready while !rvalid is ignored. rdata is stable while rvalid && !rready.
- Simultaneous pop and load (rvalid && rready && !rempty): new word replaces old with no bubble; rvalid stays 1.
- Level: wbin = gray2bin(rq2_wptr). rlevel <= (wbin - rbinnext) mod 2^(ADDRSIZE+1), plus the next-cycle rvalid. Maximum 2^ADDRSIZE+1.
- ralmost_empty is a combinational compare on the registered rlevel.
- Wrap-around: the pointer MSB toggles on every pass through the RAM. Empty is detected only on full Gray equality, never on address equality.
- Mid-operation reset: all outputs return to reset values asynchronously. Any in-flight word in rdata is discarded. The write side is reset together by system convention.

## Timing
- Latency: rq2_wptr change → rempty falls next edge → rvalid rises the edge after, with load. First word appears 2 rclk after the synchronized pointer moves.
- Sustained throughput: 1 word/cycle while RAM is non-empty and rready=1.
- rptr updates on the same edge as the RAM pop. The write side sees it after its 2-flop synchronizer.
- rempty is pessimistic: it may stay 1 one cycle longer than strictly necessary, and never falls early.
- rlevel lags rq2_wptr by 1 cycle.

## Structure
- Shared include/package: Gray↔binary conversion function and the pointer width constant (ADDRSIZE+1), common with the write-side controller.
- Sub-module async_fifo_gray2bin: parameterized XOR-prefix converter, purely combinational, instantiated once for wbin.
- Top file holds pointer, empty, output-stage and level registers only.

## Test plan
- Reset: assert rrst_n=0 mid-stream → rempty=1, rvalid=0, rptr=0, rlevel=0, ralmost_empty=1 immediately; all hold until a pointer change.
- Single word: rq2_wptr 0→1 (Gray 00001), rready=0 → rempty=0 at +1, rvalid=1 and rdata=mem[0] at +2, rempty=1, rptr=00001, rlevel=1.
- Streaming: 16 words in RAM, rready=1 continuously → 16 consecutive rvalid cycles, data in order, rlevel decrements by 1 per cycle, ralmost_empty rises when rlevel reaches 2.
- Backpressure: rvalid=1, rready=0 for 5 cycles with 3 words in RAM → rdata stable, rbin unchanged, rlevel=4.
- Wrap: drive 40 writes/reads through a depth-16 FIFO → rptr passes Gray of 16 and 32, MSB toggles, no false empty or data loss, order preserved.
- Simultaneous pop/load: rvalid=1, rready=1, rempty=0 → rdata switches to next word the same edge, rvalid stays 1, rptr advances by one.
